// File: rtl/mem_sram_slave.sv
// mem_sram_slave: memory-side slave behind the two-master arbiter.
// It latches one request and waits WAIT_CYCLES states. It then performs the
// access on a 64-bit-wide RAM and returns a one-cycle HREADY pulse with
// HRDATA and HRESP.
// Optional feature macro: MEM_SRAM_HSIZE_EN adds the HSIZE port for
// byte/half/word/dword naturally aligned sub-word accesses.
module mem_sram_slave #(
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        PSEL,
    input  logic [63:0] PADDR,
    input  logic        HWRITE,
    input  logic [63:0] PDATA,
`ifdef MEM_SRAM_HSIZE_EN
    input  logic [1:0]  HSIZE,
`endif
    output logic [63:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic        BUSY
);

    localparam int          WORDS = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN  = 64'(WORDS) * 64'd8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               state;
    state_t               next_state;
    logic [3:0]           cnt;
    logic                 accept;
    logic                 access;

    logic [63:0]          addr_p0;
    logic [63:0]          data_p0;
    logic                 write_p0;

    logic [63:0]          offset_p0;
    logic                 in_range_p0;
    logic                 misalign_p0;
    logic                 ok_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    logic [7:0]           lanes_p0;
    logic [5:0]           shift_p0;
    logic [63:0]          wmask_p0;
    logic [63:0]          rword_p0;
    logic [63:0]          rdata_p0;
    logic [63:0]          wdata_p0;

    logic [63:0]          mem [0:WORDS-1];

    // One enable bit per byte lane expanded to a 64-bit bit mask.
    function automatic logic [63:0] expand_mask(input logic [7:0] lanes);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{lanes[i]}};
        end
        return m;
    endfunction

`ifdef MEM_SRAM_HSIZE_EN
    logic [1:0] size_p0;

    // Byte lanes touched by a naturally aligned access of the given size.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    // An access is misaligned when the byte offset is not a multiple of its size.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = off[0];
            2'd2:    r = |off[1:0];
            default: r = |off;
        endcase
        return r;
    endfunction

    assign lanes_p0    = lane_mask(size_p0, addr_p0[2:0]);
    assign misalign_p0 = misaligned(size_p0, addr_p0[2:0]);
    assign shift_p0    = {addr_p0[2:0], 3'b000};
`else
    assign lanes_p0    = 8'hFF;
    assign misalign_p0 = 1'b0;
    assign shift_p0    = 6'd0;
`endif

    // Decode of the latched request: a wrapped subtraction also catches addresses below the base.
    assign offset_p0   = addr_p0 - BASE_ADDR;
    assign in_range_p0 = (addr_p0 >= BASE_ADDR) && (offset_p0 < SPAN);
    assign ok_p0       = in_range_p0 && !misalign_p0;
    assign idx_p0      = offset_p0[DEPTH_LOG2+2:3];
    assign wmask_p0    = expand_mask(lanes_p0);
    assign rword_p0    = mem[idx_p0];
    assign rdata_p0    = (rword_p0 & wmask_p0) >> shift_p0;
    assign wdata_p0    = data_p0 << shift_p0;

    assign HREADY = (state == S_RESP);
    assign BUSY   = (state == S_WAIT);

    // Next-state logic: accept in IDLE or back-to-back from RESP, access when the wait count expires.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            S_IDLE: begin
                if (PSEL) begin
                    accept     = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    access     = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (PSEL) begin
                    accept     = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Control state, wait counter and registered response; reset aborts any access in flight.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            HRDATA <= 64'd0;
            HRESP  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                HRESP  <= !ok_p0;
                HRDATA <= (ok_p0 && !write_p0) ? rdata_p0 : 64'd0;
            end else if (state == S_RESP) begin
                HRESP  <= 1'b0;
                HRDATA <= 64'd0;
            end
        end
    end

    // Request capture at acceptance; later bus changes are ignored until the next accept.
    always_ff @(posedge HCLK) begin
        if (accept) begin
            addr_p0  <= PADDR;
            data_p0  <= PDATA;
            write_p0 <= HWRITE;
`ifdef MEM_SRAM_HSIZE_EN
            size_p0  <= HSIZE;
`endif
        end
    end

    // RAM write with byte-lane merge; only in-range aligned writes reach the array.
    always_ff @(posedge HCLK) begin
        if (access && write_p0 && ok_p0) begin
            mem[idx_p0] <= (rword_p0 & ~wmask_p0) | (wdata_p0 & wmask_p0);
        end
    end

endmodule

// File: tb/tb_mem_sram_slave.sv
// Scoreboard bench for mem_sram_slave: one instance with WAIT_CYCLES=2, one with 0.
module tb_mem_sram_slave;

    localparam int W2 = 2;
    localparam int W0 = 0;

    typedef struct {
        logic [63:0] data;
        logic        resp;
        int          cyc;
    } exp_t;

    logic        HCLK   = 1'b0;
    logic        HRESET = 1'b1;
    logic        PSEL   = 1'b0;
    logic        PSEL0  = 1'b0;
    logic        HWRITE = 1'b0;
    logic [63:0] PADDR  = 64'd0;
    logic [63:0] PDATA  = 64'd0;
`ifdef MEM_SRAM_HSIZE_EN
    logic [1:0]  HSIZE  = 2'd3;
`endif

    logic [63:0] rdata2, rdata0;
    logic        ready2, ready0, resp2, resp0, busy2, busy0;

    exp_t q2[$];
    exp_t q0[$];
    exp_t e2, e0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mem_sram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(W2), .BASE_ADDR(64'h0000_0000_8000_0000)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .PSEL(PSEL), .PADDR(PADDR), .HWRITE(HWRITE), .PDATA(PDATA),
`ifdef MEM_SRAM_HSIZE_EN
        .HSIZE(HSIZE),
`endif
        .HRDATA(rdata2), .HREADY(ready2), .HRESP(resp2), .BUSY(busy2));

    mem_sram_slave #(.DEPTH_LOG2(10), .WAIT_CYCLES(W0), .BASE_ADDR(64'h0000_0000_8000_0000)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .PSEL(PSEL0), .PADDR(PADDR), .HWRITE(HWRITE), .PDATA(PDATA),
`ifdef MEM_SRAM_HSIZE_EN
        .HSIZE(HSIZE),
`endif
        .HRDATA(rdata0), .HREADY(ready0), .HRESP(resp0), .BUSY(busy0));

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every HREADY pulse pops one expected response.
    always @(negedge HCLK) begin
        if (ready2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_hready", 64'd1, 64'd0);
            end else begin
                e2 = q2.pop_front();
                chk("dut2_hrdata", rdata2, e2.data);
                chk("dut2_hresp", 64'(resp2), 64'(e2.resp));
                chk("dut2_ready_cycle", 64'(cyc), 64'(e2.cyc));
                chk("dut2_busy_in_resp", 64'(busy2), 64'd0);
            end
        end
        if (ready0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_hready", 64'd1, 64'd0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_hrdata", rdata0, e0.data);
                chk("dut0_hresp", 64'(resp0), 64'(e0.resp));
                chk("dut0_ready_cycle", 64'(cyc), 64'(e0.cyc));
            end
        end
    end

    // Present a request, wait for the accepting edge, optionally queue its expected response.
    task automatic issue(input int which, input logic [63:0] addr, input logic wr,
                         input logic [63:0] data, input logic push,
                         input logic [63:0] exp_data, input logic exp_resp, input logic hold);
        exp_t e;
        PADDR  = addr;
        HWRITE = wr;
        PDATA  = data;
        if (which == 0) PSEL0 = 1'b1;
        else            PSEL  = 1'b1;
        @(posedge HCLK);
        #1;
        e.data = exp_data;
        e.resp = exp_resp;
        if (which == 0) begin
            e.cyc = cyc + W0 + 1;
            if (push) q0.push_back(e);
            if (!hold) PSEL0 = 1'b0;
        end else begin
            e.cyc = cyc + W2 + 1;
            if (push) q2.push_back(e);
            if (!hold) PSEL = 1'b0;
        end
    endtask

    // Queue an extra expectation at an explicit cycle (back-to-back second response).
    task automatic expect_at(input int which, input logic [63:0] exp_data, input logic exp_resp, input int at);
        exp_t e;
        e.data = exp_data;
        e.resp = exp_resp;
        e.cyc  = at;
        if (which == 0) q0.push_back(e);
        else            q2.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 50) begin
            @(posedge HCLK);
            n++;
        end
        if (q2.size() != 0 || q0.size() != 0) begin
            chk("drain_timeout_pending", 64'(q2.size() + q0.size()), 64'd0);
            q2.delete();
            q0.delete();
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr2(input logic [63:0] a, input logic [63:0] d, input logic resp);
        issue(2, a, 1'b1, d, 1'b1, 64'd0, resp, 1'b0);
        drain();
    endtask

    task automatic rd2(input logic [63:0] a, input logic [63:0] d, input logic resp);
        issue(2, a, 1'b0, 64'd0, 1'b1, d, resp, 1'b0);
        drain();
    endtask

    initial begin
        int k;
        // Reset state
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_hrdata", rdata2, 64'd0);
        chk("reset_hready", 64'(ready2), 64'd0);
        chk("reset_hresp", 64'(resp2), 64'd0);
        chk("reset_busy", 64'(busy2), 64'd0);
        chk("reset_dut0_hready", 64'(ready0), 64'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Write then read, WAIT_CYCLES=2
        wr2(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 1'b0);
        wr2(64'h8000_0018, 64'h1111_2222_3333_4444, 1'b0);
        rd2(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 1'b0);

        // BUSY during WAIT
        issue(2, 64'h8000_0018, 1'b0, 64'd0, 1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
        chk("busy_in_wait", 64'(busy2), 64'd1);
        drain();

        // Back-to-back: PSEL held through RESP with new address
        issue(2, 64'h8000_0010, 1'b0, 64'd0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
        k = cyc;
        PADDR = 64'h8000_0018;
        expect_at(2, 64'h1111_2222_3333_4444, 1'b0, k + 2 * W2 + 3);
        repeat (W2 + 2) @(posedge HCLK);
        #1;
        PSEL = 1'b0;
        drain();

        // Out of range: below base and past the end; aliasing words must be untouched
        wr2(64'h8000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        wr2(64'h8000_1FF8, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);
        wr2(64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        wr2(64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        rd2(64'h8000_2000, 64'd0, 1'b1);
        rd2(64'h8000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        rd2(64'h8000_1FF8, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0);

        // Asynchronous reset mid-WAIT aborts a pending write
        issue(2, 64'h8000_0010, 1'b1, 64'hCAFE_CAFE_CAFE_CAFE, 1'b0, 64'd0, 1'b0, 1'b0);
        @(posedge HCLK);
        #3;
        HRESET = 1'b1;
        #1;
        chk("abort_hrdata", rdata2, 64'd0);
        chk("abort_hready", 64'(ready2), 64'd0);
        chk("abort_hresp", 64'(resp2), 64'd0);
        chk("abort_busy", 64'(busy2), 64'd0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;
        rd2(64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 1'b0);

        // Zero wait states: HREADY one cycle after acceptance
        issue(0, 64'h8000_0010, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'd0, 1'b0, 1'b0);
        drain();
        issue(0, 64'h8000_0010, 1'b0, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        drain();
        issue(0, 64'h8000_0010, 1'b0, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
        k = cyc;
        expect_at(0, 64'h0123_4567_89AB_CDEF, 1'b0, k + 2 * W0 + 3);
        repeat (W0 + 2) @(posedge HCLK);
        #1;
        PSEL0 = 1'b0;
        drain();

`ifdef MEM_SRAM_HSIZE_EN
        // Sub-word accesses
        HSIZE = 2'd3;
        wr2(64'h8000_0010, 64'd0, 1'b0);
        HSIZE = 2'd0;
        wr2(64'h8000_0013, 64'h1234_5678_9ABC_DEAA, 1'b0);
        HSIZE = 2'd3;
        rd2(64'h8000_0010, 64'h0000_0000_AA00_0000, 1'b0);
        HSIZE = 2'd1;
        wr2(64'h8000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        HSIZE = 2'd0;
        rd2(64'h8000_0013, 64'h0000_0000_0000_00AA, 1'b0);
        HSIZE = 2'd2;
        rd2(64'h8000_0014, 64'd0, 1'b0);
        HSIZE = 2'd3;
        rd2(64'h8000_0010, 64'h0000_0000_AA00_0000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_sram_slave.md
Name: mem_sram_slave

Overview:
- Memory-side slave directly downstream of the two-master memory arbiter.
- Consumes the arbitrated PADDR/HWRITE/PDATA request and performs the access on an internal 64-bit-wide synchronous RAM with programmable wait states.
- Returns read data, a one-cycle done pulse (HREADY) and an error flag (HRESP) to the core.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 64-bit RAM words.
- WAIT_CYCLES, 2, extra wait states inserted before the access (0..15).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.

Ports:
- HCLK  input  1  single clock, rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  request valid (arbiter HTRANS_1 | HTRANS_2).
- PADDR  input  64  byte address.
- HWRITE  input  1  1 = write, 0 = read.
- PDATA  input  64  write data.
- HRDATA  output  64  read data; valid while HREADY=1.
- HREADY  output  1  one-cycle completion pulse.
- HRESP  output  1  error, valid with HREADY.
- BUSY  output  1  request accepted, not yet completed.

Behaviour:
- Reset (async, HRESET=1):
  - state=IDLE.
  - HRDATA=0, HREADY=0, HRESP=0, BUSY=0, wait counter=0.
  - RAM contents not reset.
  - Reset mid-access aborts it; a pending write is not performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - PSEL=1 at an edge → latch PADDR/HWRITE/PDATA, cnt=WAIT_CYCLES, go WAIT, BUSY=1.
  - PSEL=0 → stay.
- WAIT:
  - cnt!=0 at edge → cnt-1, stay.
  - cnt==0 at edge → perform access, register result, go RESP.
  - PADDR/PDATA changes during WAIT are ignored (latched copy used).
- RESP:
  - HREADY=1, BUSY=0 for exactly one cycle.
  - PSEL=1 at the edge ending RESP → back-to-back accept, go WAIT. Otherwise go IDLE.
  - Requester must drop PSEL during the HREADY cycle unless issuing a new request.
- Latency: acceptance at edge k → HREADY high after edge k+WAIT_CYCLES+1. WAIT_CYCLES=0 gives 1 cycle.
- Address decode:
  - offset = latched PADDR - BASE_ADDR (64-bit unsigned); word index = offset[DEPTH_LOG2+2:3].
  - Out of range: PADDR < BASE_ADDR or offset >= 8<<DEPTH_LOG2. Result: HRESP=1, HRDATA=0, no write.
- Read: HRDATA = RAM[index].
- Write: RAM[index] = latched PDATA; HRDATA=0.
- HRESP=0 on any in-range access; HRESP and HRDATA return to 0 when leaving RESP.
- PADDR[2:0] ignored (full-word access) unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_SRAM_HSIZE_EN.
- With the macro defined:
  - Adds input HSIZE (2 bits): 0=byte, 1=half, 2=word, 3=dword.
  - Access is natural-aligned at PADDR[2:0].
  - Writes update only the addressed bytes, taking data from PDATA low bits.
  - Reads return the addressed bytes zero-extended at bit 0.
  - Misaligned access (PADDR[2:0] not a multiple of the size) → HRESP=1, no write, HRDATA=0.
- Without the macro: no HSIZE port; every access is a full 64-bit word.

Test Plan:
- Reset: assert HRESET asynchronously mid-WAIT → HRDATA=0, HREADY=0, HRESP=0, BUSY=0 immediately. After release, a read of the aborted write address returns the old value.
- Write then read (WAIT_CYCLES=2): write 64'hDEAD_BEEF_0123_4567 to 0x8000_0010, accepted at edge k → HREADY at edge k+3, HRESP=0. Read at 0x8000_0010 → HRDATA=64'hDEAD_BEEF_0123_4567.
- Zero wait (WAIT_CYCLES=0): read accepted at edge k → HREADY high exactly one cycle after edge k+1.
- Back-to-back: PSEL held through RESP with a new address 0x8000_0018 → second access accepted without an IDLE cycle. Two HREADY pulses spaced WAIT_CYCLES+2 cycles apart.
- Out of range: write to 0x7FFF_FFF8 and to 0x8000_2000 (DEPTH_LOG2=10) → HRESP=1 with HREADY, RAM unchanged.
- MEM_SRAM_HSIZE_EN: byte write 8'hAA to 0x8000_0013 over 64'h0, then dword read of 0x8000_0010 → 64'h0000_0000_AA00_0000. Half-word write to 0x8000_0011 → HRESP=1.
